fir_mac_seq: RTL



---
 rtl/fir_mac_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR multiply-accumulate: snapshots N taps on start, then
// accumulates snap[i]*coef[i] over N cycles through one multiplier.
module fir_mac_seq #(
  parameter int N         = 8,
  parameter int ACC_W     = 35,
  parameter int OUT_SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*N-1:0]      taps,
  input  logic                 start,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [15:0]          coef_data,
  output logic [15:0]          y,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int IDX_W = $clog2(N);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  state, state_next;
  logic signed [15:0]      coef [N];
  logic signed [15:0]      snap [N];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic signed [31:0]      snap_sel, coef_sel, prod;
  logic signed [ACC_W-1:0] prod_ext, shifted;
  logic [15:0]             y_sat;
  logic                    last_tap;

  assign snap_sel = 32'(snap[idx]);
  assign coef_sel = 32'(coef[idx]);
  assign prod     = snap_sel * coef_sel;
  assign prod_ext = ACC_W'(prod);
  assign shifted  = acc >>> OUT_SHIFT;
  assign last_tap = (idx == IDX_W'(N - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    // NOTE: default first so every path assigns y_sat; otherwise a latch is inferred.
    y_sat = shifted[15:0];
    if (shifted > Y_MAX)      y_sat = 16'h7FFF;
    else if (shifted < Y_MIN) y_sat = 16'h8000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (last_tap) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the coefficient and snapshot files need a defined reset value,
      // so they are plain flops, not a RAM that could not be cleared.
      for (int i = 0; i < N; i++) begin
        coef[i] <= '0;
        snap[i] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values.
      y_valid <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          // The write lands on the start edge too, so it is used by this sample.
          if (coef_we) coef[coef_addr] <= coef_data;
          if (start) begin
            for (int i = 0; i < N; i++) snap[i] <= taps[16*i +: 16];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        DONE: begin
          y       <= y_sat;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
